// File: rtl/fetch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fetch_ctrl_pkg
// Shared types for the instruction-fetch controller and its output FIFO.
//   insn_t          : 32-bit instruction word
//   INSN_NOP        : instruction substituted for faulted fetches (addi x0,x0,0)
//   fetch_entry_t   : one fetched instruction as seen by decode {pc, insn, fault}
//   fetch_state_e   : fetch FSM states {RUN, HALT}
//   IDLE_ENTRY      : value presented on the FIFO head while it is empty
//   pc_out_of_range : true when a full word at pc does not fit in the memory
// -----------------------------------------------------------------------------
package fetch_ctrl_pkg;

  typedef logic [31:0] insn_t;

  localparam insn_t INSN_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    insn_t       insn;
    logic        fault;
  } fetch_entry_t;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

  localparam fetch_entry_t IDLE_ENTRY = '{pc: 32'h0, insn: INSN_NOP, fault: 1'b0};

  // The last legal word address is imem_size-4; anything above it faults.
  function automatic logic pc_out_of_range(input logic [31:0] pc,
                                           input int unsigned imem_size);
    logic [31:0] last_pc;
    last_pc = 32'(imem_size) - 32'd4;
    return pc > last_pc;
  endfunction

endpackage

// File: rtl/fetch_ctrl_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Synchronous FIFO of fetch_entry_t between the fetch controller and decode.
// Flush takes precedence over push and pop. A pop on an empty FIFO is ignored.
// The head is shown as IDLE_ENTRY while the FIFO is empty.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_push, i_entry: write one entry
//   i_pop          : remove the head
//   i_flush        : discard all entries
//   o_head         : head entry
//   o_valid        : FIFO not empty
//   o_count        : number of stored entries, $clog2(DEPTH+1) bits
// -----------------------------------------------------------------------------
module fetch_fifo
  import fetch_ctrl_pkg::*;
#(
  parameter  int DEPTH = 3,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  fetch_entry_t i_entry,
  input  logic         i_pop,
  input  logic         i_flush,
  output fetch_entry_t o_head,
  output logic         o_valid,
  output logic [CW-1:0] o_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t    mem_q [DEPTH];
  logic [PW-1:0]   rd_q;
  logic [PW-1:0]   wr_q;
  logic [CW-1:0]   count_q;
  logic            pop_e;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign pop_e = i_pop && (count_q != '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else if (i_flush) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      if (i_push) wr_q <= ptr_inc(wr_q);
      if (pop_e)  rd_q <= ptr_inc(rd_q);
      case ({i_push, pop_e})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: the head is masked to IDLE_ENTRY while empty.
  always_ff @(posedge i_clk) begin
    if (i_push && !i_flush) mem_q[wr_q] <= i_entry;
  end

  assign o_valid = (count_q != '0);
  assign o_head  = o_valid ? mem_q[rd_q] : IDLE_ENTRY;
  assign o_count = count_q;

endmodule

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
// Instruction-fetch controller. Owns the fetch PC, issues one address per cycle
// to a single-cycle-latency instruction memory, captures the returned word one
// cycle later into an output FIFO towards decode, applies redirects with a
// flush and halts after a faulting fetch until the next redirect.
//
// Optional feature macro: FETCH_CTRL_PERF_EN adds o_perf_fetched and
// o_perf_stalled (saturating, reset-only, survive redirects).
//
// Ports:
//   i_clk, i_rst_n          : clock, asynchronous active-low reset
//   o_imem_pc               : memory read address (the fetch PC)
//   i_imem_insn             : memory read data, valid the cycle after the address
//   i_imem_exception        : misalignment flag, combinational on o_imem_pc
//   i_redirect_valid/_pc    : redirect request and target from execute
//   o_valid/o_insn/o_pc/o_fault, i_ready : head of the fetch FIFO to decode
//   o_dbg_state             : current fetch FSM state
//   o_perf_fetched/_stalled : performance counters (FETCH_CTRL_PERF_EN only)
//
// Handshake: decode takes the head on any rising edge where o_valid && i_ready.
// o_valid and the head fields hold steady until that happens; i_ready may be
// asserted without o_valid and has no combinational path to o_imem_pc.
// -----------------------------------------------------------------------------
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          IMEM_SIZE = 512,
  parameter int          DEPTH     = 3
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  output logic [31:0]  o_imem_pc,
  input  insn_t        i_imem_insn,
  input  logic         i_imem_exception,
  input  logic         i_redirect_valid,
  input  logic [31:0]  i_redirect_pc,
  output logic         o_valid,
  output insn_t        o_insn,
  output logic [31:0]  o_pc,
  output logic         o_fault,
  input  logic         i_ready,
`ifdef FETCH_CTRL_PERF_EN
  output logic [31:0]  o_perf_fetched,
  output logic [31:0]  o_perf_stalled,
`endif
  output fetch_state_e o_dbg_state
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]  pc_q;
  logic         inflight_q;
  logic [31:0]  inflight_pc_q;
  logic         inflight_fault_q;
  fetch_state_e state_q;

  logic [CW-1:0] fifo_count;
  logic [CW:0]   occupancy;
  logic          fifo_valid;
  fetch_entry_t  fifo_head;
  fetch_entry_t  push_entry;
  logic          issue;
  logic          issue_fault;
  logic          push;
  logic          pop;

  // Slots already promised: stored entries plus the word coming back next cycle.
  // Only registered terms, so decode backpressure never reaches the memory address.
  assign occupancy   = {1'b0, fifo_count} + (CW + 1)'(inflight_q);
  assign issue       = (state_q == RUN) && !i_redirect_valid &&
                       (occupancy < (CW + 1)'(DEPTH));
  assign issue_fault = i_imem_exception | pc_out_of_range(pc_q, IMEM_SIZE);

  assign push       = inflight_q;
  assign push_entry = '{pc:    inflight_pc_q,
                        insn:  inflight_fault_q ? INSN_NOP : i_imem_insn,
                        fault: inflight_fault_q};
  assign pop        = fifo_valid && i_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc_q             <= RESET_PC;
      inflight_q       <= 1'b0;
      inflight_pc_q    <= 32'h0;
      inflight_fault_q <= 1'b0;
      state_q          <= RUN;
    end else if (i_redirect_valid) begin
      // Dropping inflight_q discards the word returning for the old stream.
      pc_q       <= i_redirect_pc;
      inflight_q <= 1'b0;
      state_q    <= RUN;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        pc_q             <= pc_q + 32'd4;
        inflight_pc_q    <= pc_q;
        inflight_fault_q <= issue_fault;
        if (issue_fault) state_q <= HALT;
      end
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (push),
    .i_entry (push_entry),
    .i_pop   (pop),
    .i_flush (i_redirect_valid),
    .o_head  (fifo_head),
    .o_valid (fifo_valid),
    .o_count (fifo_count)
  );

  assign o_imem_pc   = pc_q;
  assign o_valid     = fifo_valid;
  assign o_insn      = fifo_head.insn;
  assign o_pc        = fifo_head.pc;
  assign o_fault     = fifo_head.fault;
  assign o_dbg_state = state_q;

`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_stalled_q;

  // A return coinciding with a redirect is flushed, so it is not counted.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      perf_fetched_q <= 32'h0;
      perf_stalled_q <= 32'h0;
    end else begin
      if (push && !i_redirect_valid && (perf_fetched_q != 32'hFFFF_FFFF))
        perf_fetched_q <= perf_fetched_q + 32'd1;
      if (fifo_valid && !i_ready && (perf_stalled_q != 32'hFFFF_FFFF))
        perf_stalled_q <= perf_stalled_q + 32'd1;
    end
  end

  assign o_perf_fetched = perf_fetched_q;
  assign o_perf_stalled = perf_stalled_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl
// Bench for fetch_ctrl: directed latency/backpressure/redirect/fault scenarios
// followed by randomized ready and redirect traffic. The reference model says
// that after reset or a redirect to T, decode sees the word stream T, T+4, ...
// up to and including the first faulting address, and nothing after it.
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  localparam int          DEPTH     = 3;
  localparam int          IMEM_SIZE = 512;
  localparam logic [31:0] RESET_PC  = 32'h0;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic [31:0]  imem_pc;
  logic [31:0]  imem_insn;
  logic         imem_exc;
  logic         redirect_valid;
  logic [31:0]  redirect_pc;
  logic         out_valid;
  logic [31:0]  out_insn;
  logic [31:0]  out_pc;
  logic         out_fault;
  logic         ready;
  fetch_state_e dbg_state;
`ifdef FETCH_CTRL_PERF_EN
  logic [31:0]  perf_fetched;
  logic [31:0]  perf_stalled;
`endif

  fetch_ctrl #(.RESET_PC(RESET_PC), .IMEM_SIZE(IMEM_SIZE), .DEPTH(DEPTH)) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .o_imem_pc        (imem_pc),
    .i_imem_insn      (imem_insn),
    .i_imem_exception (imem_exc),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .o_valid          (out_valid),
    .o_insn           (out_insn),
    .o_pc             (out_pc),
    .o_fault          (out_fault),
    .i_ready          (ready),
`ifdef FETCH_CTRL_PERF_EN
    .o_perf_fetched   (perf_fetched),
    .o_perf_stalled   (perf_stalled),
`endif
    .o_dbg_state      (dbg_state)
  );

  // ---------------- instruction memory model ----------------
  logic [31:0] mem [128];
  always @(posedge clk) imem_insn <= mem[imem_pc[8:2]];
  assign imem_exc = (imem_pc[1:0] != 2'b00);

  // ---------------- checking ----------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic [64:0] exp_q [$];   // {pc, insn, fault}

  function automatic logic ref_fault(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || (pc > 32'(IMEM_SIZE - 4));
  endfunction

  task automatic refill(input logic [31:0] target);
    logic [31:0] pc;
    logic        f;
    exp_q.delete();
    pc = target;
    for (int i = 0; i < 200; i++) begin
      f = ref_fault(pc);
      exp_q.push_back({pc, (f ? 32'h0000_0013 : mem[pc[8:2]]), f});
      if (f) break;
      pc = pc + 32'd4;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && ready) begin
        check("sb_entry_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          logic [64:0] e;
          e = exp_q.pop_front();
          check("sb_pc",    out_pc,           e[64:33]);
          check("sb_insn",  out_insn,         e[32:1]);
          check("sb_fault", 32'(out_fault),   32'(e[0]));
        end
      end
      check("fifo_no_overflow", 32'(dut.u_fifo.o_count <= DEPTH), 32'd1);
      if (redirect_valid) refill(redirect_pc);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    exp_q.delete();
    redirect_valid = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_pc",    imem_pc,        RESET_PC);
    step();
    rst_n = 1'b1;
    refill(RESET_PC);
  endtask

  task automatic redirect(input logic [31:0] target);
    step();
    redirect_valid = 1'b1;
    redirect_pc    = target;
    step();
    redirect_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n          = 1'b0;
    ready          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    for (int i = 0; i < 128; i++) mem[i] = $urandom;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_imem_pc", imem_pc,          RESET_PC);
    check("rst_valid",   32'(out_valid),   32'd0);
    check("rst_insn",    out_insn,         32'h0000_0013);
    check("rst_pc",      out_pc,           32'h0);
    check("rst_fault",   32'(out_fault),   32'd0);
    check("rst_state",   32'(dbg_state),   32'(RUN));

    // First fetch latency: issue in cycle 0, o_valid in cycle 2
    step();
    ready = 1'b1;
    rst_n = 1'b1;
    refill(RESET_PC);
    @(negedge clk); check("c0_valid", 32'(out_valid), 32'd0);
    @(negedge clk); check("c1_valid", 32'(out_valid), 32'd0);
    @(negedge clk); check("c2_valid", 32'(out_valid), 32'd1);
                    check("c2_pc", out_pc, 32'h0);   check("c2_insn", out_insn, mem[0]);
    @(negedge clk); check("c3_pc", out_pc, 32'h4);   check("c3_insn", out_insn, mem[1]);
    @(negedge clk); check("c4_pc", out_pc, 32'h8);   check("c4_insn", out_insn, mem[2]);
                    check("c4_fault", 32'(out_fault), 32'd0);

    // Backpressure from reset: exactly DEPTH entries held, PC frozen at 0xC
    ready = 1'b0;
    do_reset();
    repeat (10) @(negedge clk);
    check("bp_imem_pc", imem_pc, 32'hC);
    check("bp_count",   32'(dut.u_fifo.o_count), 32'd3);
    check("bp_head_pc", out_pc, 32'h0);
    step();
    ready = 1'b1;
    @(negedge clk); check("resume_p0_pc", imem_pc, 32'hC);
    @(negedge clk); check("resume_p1_pc", imem_pc, 32'hC);
    @(negedge clk); check("resume_p2_pc", imem_pc, 32'h10);
    repeat (6) @(negedge clk);

    // Redirect to 0x40 with a full FIFO and a coincident pop
    step();
    ready = 1'b0;
    repeat (6) step();
    ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    step();
    redirect_valid = 1'b0;
    @(negedge clk); check("rd_r1_valid", 32'(out_valid), 32'd0);
                    check("rd_r1_imem",  imem_pc, 32'h40);
    @(negedge clk); check("rd_r2_valid", 32'(out_valid), 32'd0);
    @(negedge clk); check("rd_r3_valid", 32'(out_valid), 32'd1);
                    check("rd_r3_pc",    out_pc, 32'h40);
    repeat (4) @(negedge clk);

    // Redirect to a misaligned target: one faulted NOP, then HALT
    redirect(32'h42);
    @(negedge clk); check("mis_r1_imem", imem_pc, 32'h42);
    @(negedge clk);
    @(negedge clk); check("mis_pc",    out_pc,           32'h42);
                    check("mis_insn",  out_insn,         32'h0000_0013);
                    check("mis_fault", 32'(out_fault),   32'd1);
                    check("mis_state", 32'(dbg_state),   32'(HALT));
    repeat (5) @(negedge clk);
    check("halt_imem_pc", imem_pc,        32'h46);
    check("halt_valid",   32'(out_valid), 32'd0);
    redirect(32'h80);
    repeat (4) @(negedge clk);
    check("resume_state", 32'(dbg_state), 32'(RUN));

    // Sequential run off the end of memory
    redirect(32'h1F0);
    repeat (12) @(negedge clk);
    check("end_state",    32'(dbg_state),   32'(HALT));
    check("end_valid",    32'(out_valid),   32'd0);
    check("end_sb_empty", 32'(exp_q.size()), 32'd0);

    // Randomized ready / redirect traffic with one reset in the middle
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) do_reset();
      step();
      ready = ($urandom_range(0, 99) < 70);
      if ($urandom_range(0, 99) < 5) begin
        redirect_valid = 1'b1;
        case ($urandom_range(0, 3))
          0:       redirect_pc = {23'h0, 7'($urandom_range(0, 127)), 2'b00};
          1:       redirect_pc = 32'($urandom_range(0, 511));
          2:       redirect_pc = 32'h1E0 + 32'(4 * $urandom_range(0, 7));
          default: redirect_pc = $urandom;
        endcase
      end else begin
        redirect_valid = 1'b0;
      end
    end
    step();
    redirect_valid = 1'b0;
    ready = 1'b1;
    repeat (8) @(negedge clk);

`ifdef FETCH_CTRL_PERF_EN
    // 8 pushes (0x1E4..0x1FC clean, 0x200 faulted) and 5 stalled cycles
    ready = 1'b0;
    do_reset();
    check("perf_rst_fetched", perf_fetched, 32'd0);
    check("perf_rst_stalled", perf_stalled, 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h1E4;
    step();
    redirect_valid = 1'b0;
    for (int w = 0; w < 20 && !out_valid; w++) @(negedge clk);
    check("perf_wait_valid", 32'(out_valid), 32'd1);
    repeat (4) @(negedge clk);
    step();
    ready = 1'b1;
    repeat (15) @(negedge clk);
    check("perf_fetched", perf_fetched, 32'd8);
    check("perf_stalled", perf_stalled, 32'd5);
    do_reset();
    check("perf_clr_fetched", perf_fetched, 32'd0);
    check("perf_clr_stalled", perf_stalled, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
